// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: map geometry, tap-marker payload and sequencer states.
package cnn_pkg;

  localparam int unsigned P1_W     = 12;
  localparam int unsigned C2_K     = 5;
  localparam int unsigned C2_OUT_W = P1_W - C2_K + 1;
  localparam int unsigned P1_DEPTH = P1_W * P1_W;

  // Side-band markers that travel alongside a memory read until its data returns.
  typedef struct packed {
    logic       valid;
    logic       first;
    logic       last;
    logic [2:0] row;
    logic [2:0] col;
  } tap_mark_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } p1_state_t;

endpackage

// File: rtl/p1_rd_delay.sv
// Fixed-depth delay line for tap markers; matches the P1 memory read latency.
module p1_rd_delay
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  tap_mark_t din,
  output tap_mark_t dout
);

  tap_mark_t stage [DEPTH];

  // Shift markers one stage per clock; reset flushes in-flight taps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/p1_mem_read.sv
// Read sequencer for the pooling-1 map: walks 5x5 windows for conv-2, one address per cycle.
module p1_mem_read
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W   = P1_W,
  parameter int unsigned K       = C2_K,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              tap_valid,
  output logic              first_tap,
  output logic              last_tap,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              done
);

  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned LAT_W = 2;

  p1_state_t         state, state_nxt;
  logic [2:0]        kc, kr, oc, orow;
  logic [ADDR_W-1:0] cur_addr, win_base, row_base;
  logic [LAT_W-1:0]  drain_cnt;
  tap_mark_t         iss_mark, ret_mark;

  logic issue_c, kc_end_c, kr_end_c, oc_end_c, orow_end_c, last_c;

  assign issue_c    = (state == RUN) && enable && !stall;
  assign kc_end_c   = (kc == 3'(K - 1));
  assign kr_end_c   = (kr == 3'(K - 1));
  assign oc_end_c   = (oc == 3'(OUT_W - 1));
  assign orow_end_c = (orow == 3'(OUT_W - 1));
  assign last_c     = kc_end_c && kr_end_c && oc_end_c && orow_end_c;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (issue_c && last_c) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == LAT_W'(MEM_LAT - 1)) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window/tap counters and incremental address generation; all advance only on issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc       <= '0;
      kr       <= '0;
      oc       <= '0;
      orow     <= '0;
      cur_addr <= '0;
      win_base <= '0;
      row_base <= '0;
    end else if (issue_c) begin
      if (!kc_end_c) begin
        kc       <= kc + 3'd1;
        cur_addr <= cur_addr + ADDR_W'(1);
      end else begin
        kc <= '0;
        if (!kr_end_c) begin
          kr       <= kr + 3'd1;
          cur_addr <= cur_addr + ADDR_W'(IMG_W - K + 1);
        end else begin
          kr <= '0;
          if (!oc_end_c) begin
            oc       <= oc + 3'd1;
            win_base <= win_base + ADDR_W'(1);
            cur_addr <= win_base + ADDR_W'(1);
          end else begin
            oc <= '0;
            if (!orow_end_c) begin
              orow     <= orow + 3'd1;
              row_base <= row_base + ADDR_W'(IMG_W);
              win_base <= row_base + ADDR_W'(IMG_W);
              cur_addr <= row_base + ADDR_W'(IMG_W);
            end else begin
              orow     <= '0;
              row_base <= '0;
              win_base <= '0;
              cur_addr <= '0;
            end
          end
        end
      end
    end
  end

  // Registered read port plus the markers describing the issued tap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      rd_en    <= 1'b0;
      iss_mark <= '0;
    end else begin
      rd_en <= issue_c;
      if (issue_c) begin
        addr           <= cur_addr;
        iss_mark.valid <= 1'b1;
        iss_mark.first <= (kr == 3'd0) && (kc == 3'd0);
        iss_mark.last  <= kr_end_c && kc_end_c;
        iss_mark.row   <= orow;
        iss_mark.col   <= oc;
      end else begin
        iss_mark <= '0;
      end
    end
  end

  // Counts drain cycles and raises sticky done as the final tap returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + LAT_W'(1) : '0;
      done      <= (state_nxt == DONE);
    end
  end

  p1_rd_delay #(
    .DEPTH (MEM_LAT)
  ) u_rd_delay (
    .clk   (clk),
    .reset (reset),
    .din   (iss_mark),
    .dout  (ret_mark)
  );

  assign tap_valid = ret_mark.valid;
  assign first_tap = ret_mark.first;
  assign last_tap  = ret_mark.last;
  assign out_row   = ret_mark.row;
  assign out_col   = ret_mark.col;

endmodule

// File: tb/tb_p1_mem_read.sv
// Randomized scoreboard bench for p1_mem_read at read latencies 1 and 3.
module tb_p1_mem_read;

  localparam int NTAP = 1600;

  logic       clk = 1'b0;
  logic       reset, enable, stall;
  logic [7:0] addr1, addr3;
  logic       rd1, rd3, tv1, tv3, ft1, ft3, lt1, lt3, dn1, dn3;
  logic [2:0] r1, c1, r3, c3;

  always #5 clk = ~clk;

  p1_mem_read #(.MEM_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall),
    .addr(addr1), .rd_en(rd1), .tap_valid(tv1), .first_tap(ft1), .last_tap(lt1),
    .out_row(r1), .out_col(c1), .done(dn1)
  );

  p1_mem_read #(.MEM_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall),
    .addr(addr3), .rd_en(rd3), .tap_valid(tv3), .first_tap(ft3), .last_tap(lt3),
    .out_row(r3), .out_col(c3), .done(dn3)
  );

  typedef struct {
    int addr;
    bit first;
    bit last;
    int row;
    int col;
    int cyc;
  } exp_t;

  // Tap n of the full pass, straight from window geometry.
  function automatic exp_t ref_at(int n);
    exp_t e;
    int orow, ocol, kr, kc;
    orow    = n / 200;
    ocol    = (n / 25) % 8;
    kr      = (n % 25) / 5;
    kc      = n % 5;
    e.addr  = (orow + kr) * 12 + ocol + kc;
    e.first = (kr == 0) && (kc == 0);
    e.last  = (kr == 4) && (kc == 4);
    e.row   = orow;
    e.col   = ocol;
    e.cyc   = 0;
    return e;
  endfunction

  // Reference model: records each expected issue with its cycle.
  exp_t issued[$];
  exp_t m_e;
  int   cyc = 0;
  int   idx = 0;
  int   mst = 0;
  int   last_cyc = 0;
  bit   have_last = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      issued.delete();
      idx       = 0;
      mst       = 0;
      have_last = 1'b0;
    end else begin
      cyc++;
      if (mst == 0) begin
        if (enable) mst = 1;
      end else if (mst == 1 && enable && !stall) begin
        m_e     = ref_at(idx);
        m_e.cyc = cyc;
        issued.push_back(m_e);
        idx++;
        if (idx == NTAP) begin
          mst       = 2;
          have_last = 1'b1;
          last_cyc  = cyc;
        end
      end
    end
  end

  // Scoreboard / monitor.
  int nchk = 0;
  int nerr = 0;
  int rp[2], tp[2], nrd[2], nfirst[2], nlast[2];
  bit final_req = 1'b0, final_ack = 1'b0, timeout_flag = 1'b0;

  task automatic chk(string nm, int lat, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (lat %0d) cycle %0d: got %0d, expected %0d", nm, lat, cyc, act, exp);
    end
  endtask

  task automatic mon(int d, int lat, logic [7:0] a, logic re, logic tv, logic ft, logic lt,
                     logic [2:0] r, logic [2:0] c, logic dn);
    exp_t e;
    if (reset) begin
      chk("reset_outputs", lat, 32'({a, re, tv, ft, lt, r, c, dn}), 32'd0);
      rp[d] = 0; tp[d] = 0; nrd[d] = 0; nfirst[d] = 0; nlast[d] = 0;
      return;
    end
    if (re) begin
      if (rp[d] < issued.size()) begin
        e = issued[rp[d]];
        rp[d]++;
        nrd[d]++;
        chk("rd_addr", lat, 32'(a), 32'(e.addr));
        chk("rd_cycle", lat, 32'(cyc), 32'(e.cyc));
      end else begin
        chk("rd_en_unexpected", lat, 32'd1, 32'd0);
      end
    end else if (rp[d] < issued.size() && issued[rp[d]].cyc <= cyc) begin
      chk("rd_en_missing", lat, 32'd0, 32'd1);
    end
    if (tv) begin
      if (tp[d] < issued.size()) begin
        e = issued[tp[d]];
        tp[d]++;
        chk("tap_markers", lat, 32'({ft, lt, r, c}),
            32'({e.first, e.last, 3'(e.row), 3'(e.col)}));
        chk("tap_latency", lat, 32'(cyc - e.cyc), 32'(lat));
        if (ft) nfirst[d]++;
        if (lt) nlast[d]++;
      end else begin
        chk("tap_unexpected", lat, 32'd1, 32'd0);
      end
    end else begin
      chk("idle_markers", lat, 32'({ft, lt, r, c}), 32'd0);
      if (tp[d] < issued.size() && issued[tp[d]].cyc + lat <= cyc)
        chk("tap_missing", lat, 32'd0, 32'd1);
    end
    chk("done", lat, 32'(dn), 32'(have_last && (cyc >= last_cyc + lat)));
  endtask

  always @(negedge clk) begin
    mon(0, 1, addr1, rd1, tv1, ft1, lt1, r1, c1, dn1);
    mon(1, 3, addr3, rd3, tv3, ft3, lt3, r3, c3, dn3);
    if (final_req && !final_ack) begin
      for (int d = 0; d < 2; d++) begin
        chk("rd_count", d ? 3 : 1, 32'(nrd[d]), 32'(NTAP));
        chk("first_count", d ? 3 : 1, 32'(nfirst[d]), 32'd64);
        chk("last_count", d ? 3 : 1, 32'(nlast[d]), 32'd64);
        chk("taps_returned", d ? 3 : 1, 32'(tp[d]), 32'(issued.size()));
      end
      chk("done_final", 1, 32'(dn1), 32'd1);
      chk("done_final", 3, 32'(dn3), 32'd1);
      chk("wait_budget", 0, 32'(timeout_flag), 32'd0);
      final_ack = 1'b1;
    end
  end

  // Run until stop_idx taps issued: fixed stall after addr 13, enable gap at gap_idx, random pauses.
  task automatic drive(input int stop_idx, input int gap_idx);
    int guard;
    bit did_stall, did_gap;
    guard = 0; did_stall = 1'b0; did_gap = 1'b0;
    while (idx < stop_idx && guard < 6000) begin
      guard++;
      if (idx == 7 && !did_stall) begin
        did_stall = 1'b1;
        enable = 1'b1;
        stall  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        stall = 1'b0;
      end else if (idx == gap_idx && !did_gap) begin
        did_gap = 1'b1;
        stall  = 1'b0;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        enable = 1'b1;
      end else begin
        stall  = ($urandom_range(0, 9) == 0);
        enable = ($urandom_range(0, 19) != 0);
        @(posedge clk);
        #2;
      end
    end
    if (idx < stop_idx) timeout_flag = 1'b1;
  endtask

  initial begin
    int g;
    reset  = 1'b1;
    enable = 1'b0;
    stall  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    enable = 1'b1;

    drive(700, 50);

    // Abort mid-pass and restart from scratch.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset  = 1'b0;
    enable = 1'b1;
    stall  = 1'b0;

    drive(NTAP, 225);

    g = 0;
    while (!(dn1 && dn3) && g < 50) begin
      @(posedge clk);
      g++;
    end
    if (!(dn1 && dn3)) timeout_flag = 1'b1;
    #2;

    // Enable activity after completion must not restart anything.
    repeat (20) begin
      enable = 1'($urandom_range(0, 1));
      stall  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #2;
    end

    final_req = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/p1_mem_read.md
Name: p1_mem_read

Overview:
- Read-side addresser for the pooling-1 output memory: 12x12 feature map, 144 entries, word addresses 0..143, row-major.
- Walks the 5x5 sliding windows needed by conv layer 2 and issues one read address per cycle.
- Delays valid, first-tap and last-tap markers by the memory read latency so they align with returned data at the C2 MAC.
- Produces 8x8 = 64 windows x 25 taps = 1600 reads; asserts a sticky done when finished.

Parameters:
- IMG_W, 12: input map width/height.
- K, 5: kernel width/height.
- ADDR_W, 8: memory address width.
- MEM_LAT, 1: memory read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run permission; low pauses issue.
- stall  in  1  downstream back-pressure; high blocks issue this cycle.
- addr  out  ADDR_W  read address to the P1 memory.
- rd_en  out  1  read strobe, qualifies addr.
- tap_valid  out  1  memory data valid this cycle.
- first_tap  out  1  aligned with tap_valid; first tap of a window.
- last_tap  out  1  aligned with tap_valid; 25th tap of a window.
- out_row  out  3  output-pixel row of the current tap, 0..7.
- out_col  out  3  output-pixel column of the current tap, 0..7.
- done  out  1  all 1600 taps returned; sticky.

Behaviour:
- Reset: asynchronous on reset high. All outputs 0. All counters 0. State goes to IDLE.
- Reset mid-operation: same as above; any in-flight taps are discarded.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN: when enable=1.
  - RUN -> DRAIN: after the final address (143) is issued.
  - DRAIN -> DONE: after MEM_LAT cycles.
  - DONE: absorbing until reset; enable is ignored, no restart.
- Issue condition: in RUN, issue when enable=1 and stall=0.
  - On an issue cycle, the registered addr/rd_en show the new tap on the next clock edge.
  - Otherwise rd_en=0, addr holds its value, and all counters hold.
- Issue order:
  - kc (0..K-1) fastest.
  - then kr (0..K-1).
  - then out_col (0..7).
  - then out_row (0..7).
- Address rule: addr = (out_row+kr)*IMG_W + (out_col+kc).
  - Generate incrementally; no multipliers.
  - Within a window row: +1.
  - On kc wrap: +(IMG_W-K+1) = +8.
  - Window bases held in a base register: +1 per column, reset to row base on column wrap, row base +IMG_W on row wrap.
- In-flight data: stall does not freeze the return pipeline. Downstream must absorb up to MEM_LAT taps already issued.
- Marker alignment:
  - tap_valid(t) = rd_en(t-MEM_LAT).
  - first_tap = issued tap had kr=kc=0.
  - last_tap = issued tap had kr=kc=K-1.
  - out_row and out_col travel with the same delay line.
  - All are 0 when tap_valid=0.
- done rises the cycle the last tap_valid (addr 143, last_tap=1, out_row=out_col=7) is presented. done stays 1.
- Boundaries:
  - Counter wraps occur only in the same cycle as an issue.
  - enable low and stall high together behave as a single pause.
  - enable dropping in DRAIN does not block completion.

Decomposition:
- Shared package cnn_pkg holds:
  - P1_W=12, C2_K=5, C2_OUT_W=8.
  - P1_DEPTH=144.
  - the tap-marker struct {valid, first, last, row[2:0], col[2:0]}.
  - the state enum.
- One sub-module, p1_rd_delay: a MEM_LAT-deep shift register of the tap-marker struct, with asynchronous reset to zero.

Test Plan:
- Free run, MEM_LAT=1, stall=0 -> first 25 addrs are 0,1,2,3,4,12..16,24..28,36..40,48..52.
  - Window 2 starts at 1.
  - Window 9 (row 1, col 0) starts at 12.
  - Last addr is 143.
  - Exactly 1600 rd_en pulses; done rises 1 cycle after the last rd_en.
- stall high 3 cycles mid-window (after addr 13) -> 1 additional tap_valid arrives, then none; issue resumes at addr 14; no addr skipped or repeated.
- enable low 10 cycles at a window boundary -> rd_en=0 throughout; sequence resumes with the next window base; final count is still 1600.
- reset asserted at tap 700 -> all outputs 0 immediately; after release with enable=1, the sequence restarts at addr 0.
- MEM_LAT=3 -> tap_valid, first_tap and last_tap lag rd_en by exactly 3 cycles; 64 first_tap and 64 last_tap pulses; done 3 cycles after the last rd_en.
- After done, toggle enable -> no further rd_en; done remains 1 until reset.
